relu_maxpool: RTL
=================

RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 Parameter Y, default 8: base data width; input sample is Y+2 bits signed, matching the three-channel adder output width.
REQ-002 Parameter W, default 24: feature-map width in pixels; SHALL be even and >= 2.
REQ-003 Parameter H, default 24: feature-map height in rows; SHALL be even and >= 2.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 in_valid  input  1  data_in carries a valid pixel this cycle.
REQ-007 data_in  input  Y+2 signed  summed convolution pixel, raster order (row-major, col 0..W-1 then next row).
REQ-008 out_valid  output  1  registered, one-cycle pulse per pooled pixel.
REQ-009 data_out  output  Y+1 unsigned  registered pooled pixel.
REQ-010 frame_done  output  1  registered, one-cycle pulse coincident with the last pooled pixel of a frame.

Function
REQ-011 ReLU applied per input pixel: value < 0 -> 0, else value; result fits Y+1 bits unsigned with no saturation.
REQ-012 Column counter col (0..W-1) and row counter row (0..H-1) SHALL advance only on cycles with in_valid=1; in_valid=0 cycles change no state except clearing out_valid/frame_done.
REQ-013 col wraps W-1 -> 0 with row increment; at row=H-1, col=W-1 both wrap to 0 (new frame starts on next valid beat).
REQ-014 Even row, even col: ReLU pixel stored in horizontal hold register.
REQ-015 Even row, odd col: max(hold, ReLU pixel) written to line buffer entry col/2 (W/2 entries, Y+1 bits each).
REQ-016 Odd row, even col: ReLU pixel stored in hold register.
REQ-017 Odd row, odd col: data_out <= max(linebuf[col/2], hold, ReLU pixel); out_valid <= 1 on the next clock edge (latency one cycle from the accepting beat).
REQ-018 Comparisons unsigned on ReLU outputs; ties produce the equal value.
REQ-019 out_valid SHALL be 0 in every cycle not following an odd-row/odd-col accepted beat; data_out holds its last value when out_valid=0.
REQ-020 frame_done SHALL be 1 exactly in the cycle out_valid=1 for the beat at row=H-1, col=W-1.
REQ-021 Output rate: (W/2)*(H/2) pooled pixels per frame, emitted in raster order of the pooled map.
REQ-022 No backpressure: the block accepts a beat every cycle; back-to-back frames with no gap SHALL be handled without loss.

Reset
REQ-023 rst_n=0 SHALL immediately clear col, row, hold, out_valid, frame_done and data_out to 0, regardless of clk.
REQ-024 Line buffer contents need not be reset; they are always written (even row) before being read (odd row).
REQ-025 Reset mid-frame abandons the partial frame; first valid beat after rst_n rises is treated as row 0, col 0.

Verification
REQ-026 W=4,H=2, row0 = {1,5,-3,2}, row1 = {4,0,7,-8} contiguous -> two outputs: 5 then 7, frame_done with the second, each out_valid one cycle after row1 col1/col3 beats.
REQ-027 All-negative frame (every pixel -100, Y=8) -> every data_out = 0, (W/2)*(H/2) out_valid pulses.
REQ-028 Same stimulus as REQ-026 with in_valid=0 inserted between every beat -> identical output values and count; out_valid only after accepting beats.
REQ-029 Max positive input 2^(Y+1)-1 = 511 in one pixel of each window -> data_out = 511, no overflow.
REQ-030 Two back-to-back frames, rst_n pulsed low mid-way through the first's odd row -> outputs cleared at once; the second frame pools correctly from row 0.
REQ-031 Default W=H=24, random data, compare to reference model -> 144 outputs, exactly one frame_done per frame.

Source files
------------

// File: rtl/relu_maxpool.sv
// ---------------------------------------------------------------------------
// relu_maxpool
//   Streaming ReLU followed by 2x2 / stride-2 max pooling over a raster-order
//   W x H feature map. Even rows fold each horizontal pixel pair into a
//   half-width line buffer. Odd rows combine their own pair with the stored
//   entry and emit one pooled pixel per 2x2 window.
//
// Parameters
//   Y : base data width (input is Y+2 bits signed, output Y+1 bits unsigned)
//   W : feature-map width  (even, >= 2)
//   H : feature-map height (even, >= 2)
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : data_in carries a pixel this cycle
//   data_in    : signed summed convolution pixel, raster order
//   out_valid  : one-cycle pulse per pooled pixel (registered)
//   data_out   : pooled pixel, holds its value between pulses (registered)
//   frame_done : one-cycle pulse with the last pooled pixel of a frame
// ---------------------------------------------------------------------------
module relu_maxpool #(
    parameter int Y = 8,
    parameter int W = 24,
    parameter int H = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic signed [Y+1:0] data_in,
    output logic                out_valid,
    output logic        [Y:0]   data_out,
    output logic                frame_done
);

    localparam int CW = (W > 2) ? $clog2(W)     : 1;
    localparam int RW = (H > 2) ? $clog2(H)     : 1;
    localparam int LW = (W > 2) ? $clog2(W / 2) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [Y:0]    hold;
    logic [Y:0]    linebuf [W/2];

    logic [Y:0]    relu_px;
    logic [LW-1:0] lb_idx;
    logic          col_last;
    logic          row_last;
    logic [Y:0]    pair_max;
    logic [Y:0]    pool_max;

    function automatic logic [Y:0] umax(input logic [Y:0] a, input logic [Y:0] b);
        return (a > b) ? a : b;
    endfunction

    // A non-negative value's sign bit is 0, so the low Y+1 bits hold it exactly.
    assign relu_px  = data_in[Y+1] ? '0 : data_in[Y:0];
    assign lb_idx   = LW'(col >> 1);
    assign col_last = (col == CW'(W - 1));
    assign row_last = (row == RW'(H - 1));
    assign pair_max = umax(hold, relu_px);
    assign pool_max = umax(linebuf[lb_idx], pair_max);

    // NOTE: the line buffer has no reset; each entry is written on an even row
    // before the following odd row reads it, so reset would only add area.
    always_ff @(posedge clk) begin
        if (in_valid && col[0] && !row[0])
            linebuf[lb_idx] <= pair_max;
    end

    // NOTE: all state here uses non-blocking assignments so every read in this
    // block sees the pre-edge value, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                // Raster counters; both wrap together at the end of a frame.
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (!col[0]) begin
                    hold <= relu_px;
                end else if (row[0]) begin
                    data_out   <= pool_max;
                    out_valid  <= 1'b1;
                    frame_done <= col_last && row_last;
                end
            end
        end
    end

endmodule
